// File: rtl/dmem_stage_hs.sv
// Data-memory stage between EX and WB: one load/store per handshake, lane merge on stores,
// sign/zero extension on loads, configurable read wait states and access-fault detection.
module dmem_stage_hs #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [DATA_W-1:0] req_alu_out,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [DATA_W-1:0] rsp_alu_out,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic              rsp_err
);

   localparam int unsigned NB    = DATA_W / 8;
   localparam int unsigned OFF   = $clog2(NB);
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned WI_W  = ADDR_W - OFF;

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e            state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [DATA_W-1:0] alu_q, alu_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              req_err;
   logic [ADDR_W-1:0] rd_addr;
   logic [IDX_W-1:0]  rd_idx;
   logic [DATA_W-1:0] rd_word;
   logic              wr_en;
   logic [DATA_W-1:0] wr_word;

   // Bit mask covering the low 8<<size bits; all ones for a full-width access.
   function automatic logic [DATA_W-1:0] size_mask(input logic [1:0] size);
      int unsigned nbits;
      nbits = 8 << size;
      return ~({DATA_W{1'b1}} << nbits);
   endfunction

   function automatic logic access_err(input logic [1:0] size, input logic [ADDR_W-1:0] addr);
      logic            e;
      logic [WI_W-1:0] widx;
      widx = addr[ADDR_W-1:OFF];
      e    = 1'b0;
      case (size)
         2'b01:   e = addr[0];
         2'b10:   e = |addr[1:0];
         2'b11:   e = (DATA_W == 32) || (|addr[2:0]);
         default: e = 1'b0;
      endcase
      if (64'(widx) >= 64'(DEPTH)) e = 1'b1;
      return e;
   endfunction

   function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] word,
                                                 input logic [OFF-1:0]    lane,
                                                 input logic [1:0]        size,
                                                 input logic              uns);
      logic [DATA_W-1:0] sh;
      logic [DATA_W-1:0] mask;
      logic              sign;
      sh   = word >> {lane, 3'b000};
      mask = size_mask(size);
      sign = |(sh & mask & ~(mask >> 1));
      return (sh & mask) | ((sign && !uns) ? ~mask : '0);
   endfunction

   assign req_err = access_err(req_size, req_addr);

   // In IDLE the read port follows the live request so RD_LAT = 0 loads sample at accept.
   assign rd_addr = (state_q == StIdle) ? req_addr : addr_q;
   assign rd_idx  = rd_addr[OFF+IDX_W-1:OFF];
   assign rd_word = mem_q[rd_idx];

   always_comb begin
      logic [OFF+2:0]    shamt;
      logic [DATA_W-1:0] wmask;
      shamt   = {req_addr[OFF-1:0], 3'b000};
      wmask   = size_mask(req_size) << shamt;
      wr_word = (rd_word & ~wmask) | ((req_wdata << shamt) & wmask);
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      size_d      = size_q;
      uns_d       = uns_q;
      alu_d       = alu_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      wr_en       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               addr_d = req_addr;
               size_d = req_size;
               uns_d  = req_unsigned;
               alu_d  = req_alu_out;
               wr_en  = req_we && !req_err;
               if (req_we || req_err || RD_LAT == 0) begin
                  state_d     = StResp;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = req_err;
                  rsp_rdata_d = (req_we || req_err) ? '0 :
                                extract(rd_word, req_addr[OFF-1:0], req_size, req_unsigned);
               end else begin
                  state_d = StWait;
                  cnt_d   = 2'(RD_LAT);
               end
            end
         end
         StWait: begin
            if (cnt_q == 2'd1) begin
               state_d     = StResp;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = extract(rd_word, addr_q[OFF-1:0], size_q, uns_q);
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         addr_q      <= '0;
         size_q      <= '0;
         uns_q       <= 1'b0;
         alu_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         alu_q       <= alu_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (wr_en) begin
         mem_q[rd_idx] <= wr_word;
      end
   end

   assign req_ready   = (state_q == StIdle);
   assign rsp_valid   = rsp_valid_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_alu_out = alu_q;
   assign rsp_addr    = addr_q;

endmodule

// File: tb/tb_dmem_stage_hs.sv
// Directed bench for dmem_stage_hs: 32-bit and 64-bit instances driven from vector tables,
// an RD_LAT 0..3 throughput sweep, and an asynchronous reset during a load wait.
module tb_dmem_stage_hs;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [63:0] wdata;
      logic        err;
      logic [63:0] rdata;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   int n_cmp  = 0;
   int n_fail = 0;
   int cur    = 0;

   logic        m_valid, m_ready, m_we, m_uns, m_rvalid, m_rerr;
   logic [1:0]  m_size;
   logic [31:0] m_addr, m_wdata, m_alu, m_rdata, m_ralu, m_raddr;

   logic        d_valid, d_ready, d_we, d_uns, d_rvalid, d_rerr;
   logic [1:0]  d_size;
   logic [31:0] d_addr, d_raddr;
   logic [63:0] d_wdata, d_alu, d_rdata, d_ralu;

   logic        s_valid [4];
   logic        s_ready [4];
   logic        s_rvalid [4];
   logic        s_rerr [4];
   logic [31:0] s_addr [4];
   logic [31:0] s_alu [4];
   logic [31:0] s_rdata [4];
   logic [31:0] s_ralu [4];
   logic [31:0] s_raddr [4];

   logic        mon_valid, mon_ready, mon_err;
   logic [63:0] mon_rdata, mon_alu;
   logic [31:0] mon_addr;

   dmem_stage_hs #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .RD_LAT(1)) u_dut (
      .clk(clk), .reset(reset), .req_valid(m_valid), .req_ready(m_ready), .req_we(m_we),
      .req_size(m_size), .req_unsigned(m_uns), .req_addr(m_addr), .req_wdata(m_wdata),
      .req_alu_out(m_alu), .rsp_valid(m_rvalid), .rsp_rdata(m_rdata), .rsp_alu_out(m_ralu),
      .rsp_addr(m_raddr), .rsp_err(m_rerr)
   );

   dmem_stage_hs #(.ADDR_W(32), .DATA_W(64), .DEPTH(32), .RD_LAT(2)) u_d64 (
      .clk(clk), .reset(reset), .req_valid(d_valid), .req_ready(d_ready), .req_we(d_we),
      .req_size(d_size), .req_unsigned(d_uns), .req_addr(d_addr), .req_wdata(d_wdata),
      .req_alu_out(d_alu), .rsp_valid(d_rvalid), .rsp_rdata(d_rdata), .rsp_alu_out(d_ralu),
      .rsp_addr(d_raddr), .rsp_err(d_rerr)
   );

   for (genvar g = 0; g < 4; g++) begin : g_sw
      dmem_stage_hs #(.ADDR_W(32), .DATA_W(32), .DEPTH(16), .RD_LAT(g)) u_sw (
         .clk(clk), .reset(reset), .req_valid(s_valid[g]), .req_ready(s_ready[g]),
         .req_we(1'b0), .req_size(2'b10), .req_unsigned(1'b0), .req_addr(s_addr[g]),
         .req_wdata(32'h0), .req_alu_out(s_alu[g]), .rsp_valid(s_rvalid[g]),
         .rsp_rdata(s_rdata[g]), .rsp_alu_out(s_ralu[g]), .rsp_addr(s_raddr[g]),
         .rsp_err(s_rerr[g])
      );
   end

   always_comb begin
      mon_valid = (cur == 0) ? m_rvalid : d_rvalid;
      mon_ready = (cur == 0) ? m_ready : d_ready;
      mon_err   = (cur == 0) ? m_rerr : d_rerr;
      mon_rdata = (cur == 0) ? {32'h0, m_rdata} : d_rdata;
      mon_alu   = (cur == 0) ? {32'h0, m_ralu} : d_ralu;
      mon_addr  = (cur == 0) ? m_raddr : d_raddr;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic u,
                               input logic [31:0] a, input logic [63:0] wd, input logic e,
                               input logic [63:0] rd);
      vec_t v;
      v.we = we; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd; v.err = e; v.rdata = rd;
      return v;
   endfunction

   // One handshake on the selected DUT, then checks latency and every response field.
   task automatic access(input vec_t v, input logic [63:0] alu, input int rd_lat,
                         input string tag);
      int got;
      int lat;
      int exp_lat;
      @(negedge clk);
      chk({tag, " ready"}, 64'(mon_ready), 64'd1);
      if (cur == 0) begin
         m_we = v.we; m_size = v.size; m_uns = v.uns; m_addr = v.addr;
         m_wdata = v.wdata[31:0]; m_alu = alu[31:0]; m_valid = 1'b1;
      end else begin
         d_we = v.we; d_size = v.size; d_uns = v.uns; d_addr = v.addr;
         d_wdata = v.wdata; d_alu = alu; d_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      m_valid = 1'b0;
      d_valid = 1'b0;
      got = 0;
      lat = 0;
      for (int c = 1; c <= 10 && got == 0; c++) begin
         @(negedge clk);
         if (mon_valid) begin
            got = 1;
            lat = c;
         end else begin
            chk({tag, " busy"}, 64'(mon_ready), 64'd0);
         end
      end
      exp_lat = (v.we || v.err) ? 1 : 1 + rd_lat;
      chk({tag, " rsp seen"}, 64'(got), 64'd1);
      if (got != 0) begin
         chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
         chk({tag, " err"}, 64'(mon_err), 64'(v.err));
         chk({tag, " rdata"}, mon_rdata, v.rdata);
         chk({tag, " alu"}, mon_alu, alu);
         chk({tag, " addr"}, 64'(mon_addr), 64'(v.addr));
         chk({tag, " ready in resp"}, 64'(mon_ready), 64'd0);
      end
   endtask

   vec_t mt[$];
   vec_t dt[$];

   initial begin
      // Main 32-bit instance, RD_LAT = 1, DEPTH = 256.
      mt.push_back(mk(1, 2'b10, 0, 32'h010, 64'hDEADBEEF, 0, 64'h0));
      mt.push_back(mk(0, 2'b10, 0, 32'h010, 64'h0, 0, 64'hDEADBEEF));
      mt.push_back(mk(1, 2'b00, 0, 32'h011, 64'h80, 0, 64'h0));
      mt.push_back(mk(0, 2'b10, 0, 32'h010, 64'h0, 0, 64'hDEAD80EF));
      mt.push_back(mk(0, 2'b00, 0, 32'h011, 64'h0, 0, 64'hFFFFFF80));
      mt.push_back(mk(0, 2'b00, 1, 32'h011, 64'h0, 0, 64'h00000080));
      mt.push_back(mk(0, 2'b01, 1, 32'h012, 64'h0, 0, 64'h0000DEAD));
      mt.push_back(mk(0, 2'b01, 0, 32'h012, 64'h0, 0, 64'hFFFFDEAD));
      mt.push_back(mk(0, 2'b01, 0, 32'h013, 64'h0, 1, 64'h0));
      mt.push_back(mk(0, 2'b10, 0, 32'h012, 64'h0, 1, 64'h0));
      mt.push_back(mk(1, 2'b10, 0, 32'h012, 64'h11111111, 1, 64'h0));
      mt.push_back(mk(1, 2'b01, 0, 32'h013, 64'h2222, 1, 64'h0));
      mt.push_back(mk(0, 2'b10, 0, 32'h010, 64'h0, 0, 64'hDEAD80EF));
      mt.push_back(mk(0, 2'b10, 0, 32'h400, 64'h0, 1, 64'h0));
      mt.push_back(mk(1, 2'b10, 0, 32'h400, 64'h55555555, 1, 64'h0));
      mt.push_back(mk(0, 2'b10, 0, 32'h000, 64'h0, 0, 64'h0));
      mt.push_back(mk(0, 2'b11, 0, 32'h010, 64'h0, 1, 64'h0));
      mt.push_back(mk(1, 2'b11, 0, 32'h010, 64'h77777777, 1, 64'h0));
      mt.push_back(mk(0, 2'b10, 0, 32'h010, 64'h0, 0, 64'hDEAD80EF));
      mt.push_back(mk(1, 2'b01, 0, 32'h010, 64'hA5A5, 0, 64'h0));
      mt.push_back(mk(0, 2'b10, 0, 32'h010, 64'h0, 0, 64'hDEADA5A5));
      mt.push_back(mk(1, 2'b00, 0, 32'h013, 64'h12345677, 0, 64'h0));
      mt.push_back(mk(0, 2'b10, 0, 32'h010, 64'h0, 0, 64'h77ADA5A5));
      mt.push_back(mk(0, 2'b01, 0, 32'h012, 64'h0, 0, 64'h000077AD));
      mt.push_back(mk(0, 2'b10, 0, 32'h3FC, 64'h0, 0, 64'h0));
      mt.push_back(mk(1, 2'b10, 0, 32'h3FC, 64'hCAFEF00D, 0, 64'h0));
      mt.push_back(mk(0, 2'b10, 0, 32'h3FC, 64'h0, 0, 64'hCAFEF00D));
      mt.push_back(mk(0, 2'b00, 0, 32'h3FC, 64'h0, 0, 64'h0000000D));
      mt.push_back(mk(0, 2'b00, 0, 32'h3FE, 64'h0, 0, 64'hFFFFFFFE));
      mt.push_back(mk(0, 2'b10, 0, 32'h010, 64'h0, 0, 64'h77ADA5A5));
      // 64-bit instance, RD_LAT = 2, DEPTH = 32.
      dt.push_back(mk(1, 2'b11, 0, 32'h08, 64'h0123456789ABCDEF, 0, 64'h0));
      dt.push_back(mk(0, 2'b11, 0, 32'h08, 64'h0, 0, 64'h0123456789ABCDEF));
      dt.push_back(mk(0, 2'b10, 1, 32'h0C, 64'h0, 0, 64'h0000000001234567));
      dt.push_back(mk(0, 2'b10, 0, 32'h08, 64'h0, 0, 64'hFFFFFFFF89ABCDEF));
      dt.push_back(mk(0, 2'b00, 0, 32'h0F, 64'h0, 0, 64'h0000000000000001));
      dt.push_back(mk(0, 2'b01, 0, 32'h0A, 64'h0, 0, 64'hFFFFFFFFFFFF89AB));
      dt.push_back(mk(0, 2'b11, 0, 32'h0C, 64'h0, 1, 64'h0));
      dt.push_back(mk(1, 2'b01, 0, 32'h0A, 64'hBEEF, 0, 64'h0));
      dt.push_back(mk(0, 2'b11, 0, 32'h08, 64'h0, 0, 64'h01234567BEEFCDEF));
      dt.push_back(mk(0, 2'b11, 0, 32'h100, 64'h0, 1, 64'h0));
      dt.push_back(mk(0, 2'b11, 0, 32'hF8, 64'h0, 0, 64'h0));

      reset = 1'b0;
      m_valid = 0; m_we = 0; m_size = 0; m_uns = 0; m_addr = 0; m_wdata = 0; m_alu = 0;
      d_valid = 0; d_we = 0; d_size = 0; d_uns = 0; d_addr = 0; d_wdata = 0; d_alu = 0;
      for (int k = 0; k < 4; k++) begin
         s_valid[k] = 1'b0; s_addr[k] = '0; s_alu[k] = '0;
      end
      repeat (3) @(negedge clk);
      chk("reset rsp_valid", 64'(m_rvalid), 64'd0);
      chk("reset rsp_err", 64'(m_rerr), 64'd0);
      chk("reset rsp_rdata", 64'(m_rdata), 64'd0);
      chk("reset rsp_alu", 64'(m_ralu), 64'd0);
      chk("reset rsp_addr", 64'(m_raddr), 64'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("post-reset ready", 64'(m_ready), 64'd1);
      chk("post-reset ready d64", 64'(d_ready), 64'd1);

      cur = 0;
      foreach (mt[i]) access(mt[i], 64'(32'h100 + i), 1, $sformatf("m%0d", i));
      cur = 1;
      foreach (dt[i]) access(dt[i], 64'hF000_0000_0000_0000 | 64'(i), 2, $sformatf("d%0d", i));
      cur = 0;

      // Continuous req_valid: accepts must land exactly 2+RD_LAT cycles apart.
      for (int L = 0; L < 4; L++) begin
         int acc;
         int npulse;
         int last_t;
         logic [31:0] exp_a;
         logic [31:0] exp_alu;
         acc = 0; npulse = 0; last_t = -1; exp_a = '0; exp_alu = '0;
         @(negedge clk);
         s_addr[L]  = 32'h0;
         s_alu[L]   = 32'hA000_0000 | 32'(L << 8);
         s_valid[L] = 1'b1;
         for (int t = 0; t < 60 && npulse < 4; t++) begin
            if (s_rvalid[L]) begin
               npulse++;
               chk($sformatf("sw%0d addr", L), 64'(s_raddr[L]), 64'(exp_a));
               chk($sformatf("sw%0d alu", L), 64'(s_ralu[L]), 64'(exp_alu));
               chk($sformatf("sw%0d err", L), 64'(s_rerr[L]), 64'd0);
               chk($sformatf("sw%0d rdata", L), 64'(s_rdata[L]), 64'd0);
            end
            if (s_valid[L] && s_ready[L]) begin
               if (last_t >= 0)
                  chk($sformatf("sw%0d spacing", L), 64'(t - last_t), 64'(2 + L));
               last_t  = t;
               exp_a   = s_addr[L];
               exp_alu = s_alu[L];
               acc++;
               @(posedge clk);
               #1;
               s_addr[L] = s_addr[L] + 32'd4;
               s_alu[L]  = s_alu[L] + 32'd1;
               if (acc == 4) s_valid[L] = 1'b0;
            end
            @(negedge clk);
         end
         chk($sformatf("sw%0d accepts", L), 64'(acc), 64'd4);
         chk($sformatf("sw%0d pulses", L), 64'(npulse), 64'd4);
      end

      // Async reset while a load sits in WAIT: response dropped, storage wiped.
      @(negedge clk);
      m_we = 0; m_size = 2'b10; m_uns = 0; m_addr = 32'h010; m_alu = 32'h55; m_valid = 1'b1;
      @(posedge clk);
      #1;
      m_valid = 1'b0;
      @(negedge clk);
      chk("wait ready", 64'(m_ready), 64'd0);
      reset = 1'b0;
      #1;
      chk("mid reset rsp_addr", 64'(m_raddr), 64'd0);
      chk("mid reset rsp_alu", 64'(m_ralu), 64'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("mid reset rsp_valid", 64'(m_rvalid), 64'd0);
      end
      reset = 1'b1;
      #1;
      chk("after reset ready", 64'(m_ready), 64'd1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("after reset no rsp", 64'(m_rvalid), 64'd0);
         chk("after reset rdata", 64'(m_rdata), 64'd0);
      end
      access(mk(0, 2'b10, 0, 32'h010, 64'h0, 0, 64'h0), 64'h61, 1, "r0");
      access(mk(0, 2'b10, 0, 32'h3FC, 64'h0, 0, 64'h0), 64'h62, 1, "r1");

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
